// File: rtl/uart_baud_gen_frac_if.sv
// -----------------------------------------------------------------------------
// uart_baud_gen_frac_if
//   Divisor configuration channel for the fractional baud generator.
//   A new divisor is offered with cfg_valid and is taken when cfg_ready is high.
//   An offer with an illegal integer part (< 2) is answered by a one-cycle
//   cfg_err pulse instead of being stored.
//
//   cfg_valid  master -> slave  new divisor offered
//   cfg_int    master -> slave  integer divisor, INT_W bits
//   cfg_frac   master -> slave  fractional divisor, FRAC_W bits
//   cfg_ready  slave -> master  no update pending, offer can be taken
//   cfg_err    slave -> master  one-cycle pulse, offered cfg_int < 2
// -----------------------------------------------------------------------------
interface uart_baud_gen_frac_if #(
    parameter int INT_W  = 16,
    parameter int FRAC_W = 4
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [INT_W-1:0]  cfg_int;
    logic [FRAC_W-1:0] cfg_frac;
    logic              cfg_err;

    modport master (
        output cfg_valid, cfg_int, cfg_frac,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_int, cfg_frac,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/uart_baud_gen_frac.sv
// -----------------------------------------------------------------------------
// uart_baud_gen_frac
//   Runtime-programmable fractional baud generator. Produces one-cycle
//   oversample ticks at clk / (div_int + div_frac/2^FRAC_W), plus bit-rate and
//   mid-bit strobes derived from an oversample phase counter. Divisor updates
//   arrive over a valid/ready channel and are applied only on a period
//   boundary, so no tick period is ever a blend of old and new divisor.
//
//   clk        in   system clock
//   reset      in   asynchronous, active-low reset
//   en         in   generator enable; low idles and clears the generator
//   cfg        slave modport of uart_baud_gen_frac_if (divisor channel)
//   os_tick    out  one-cycle oversample strobe
//   os_cnt     out  oversample phase 0..OVERSAMPLE-1
//   bit_tick   out  one-cycle strobe when os_cnt wraps to 0
//   mid_tick   out  one-cycle strobe when os_cnt becomes OVERSAMPLE/2
//   bclk       out  toggles on every os_tick
// -----------------------------------------------------------------------------
module uart_baud_gen_frac #(
    parameter int INT_W          = 16,
    parameter int FRAC_W         = 4,
    parameter int OVERSAMPLE     = 16,
    parameter int RESET_DIV_INT  = 3,
    parameter int RESET_DIV_FRAC = 12,
    localparam int OS_W          = $clog2(OVERSAMPLE)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    uart_baud_gen_frac_if.slave         cfg,
    output logic                        os_tick,
    output logic [OS_W-1:0]             os_cnt,
    output logic                        bit_tick,
    output logic                        mid_tick,
    output logic                        bclk
);

    // Active divisor and phase accumulator.
    logic [INT_W-1:0]  div_int_q,  div_int_d;
    logic [FRAC_W-1:0] div_frac_q, div_frac_d;
    logic [FRAC_W-1:0] acc_q,      acc_d;
    logic [INT_W-1:0]  cnt_q,      cnt_d;

    // Divisor waiting for the next period boundary.
    logic              pend_q,      pend_d;
    logic [INT_W-1:0]  pend_int_q,  pend_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;

    // Registered outputs.
    logic              os_tick_q,  os_tick_d;
    logic [OS_W-1:0]   os_cnt_q,   os_cnt_d;
    logic              bit_tick_q, bit_tick_d;
    logic              mid_tick_q, mid_tick_d;
    logic              bclk_q,     bclk_d;
    logic              cfg_err_q,  cfg_err_d;

    // The carry out of acc + div_frac stretches the current period by one clk;
    // it is evaluated with the accumulator value held since the period began.
    logic [FRAC_W:0]   frac_sum;
    logic [INT_W:0]    last_cnt;
    logic              period_end;
    logic              cfg_xfer;
    logic              cfg_bad;
    logic              apply_cfg;
    logic [OS_W-1:0]   os_cnt_nxt;

    assign frac_sum   = {1'b0, acc_q} + {1'b0, div_frac_q};
    assign last_cnt   = {1'b0, div_int_q}
                      + {{INT_W{1'b0}}, frac_sum[FRAC_W]}
                      - (INT_W+1)'(1);
    assign period_end = en & ({1'b0, cnt_q} == last_cnt);

    assign cfg_xfer   = cfg.cfg_valid & ~pend_q;
    assign cfg_bad    = (cfg.cfg_int < INT_W'(2));
    // With the generator idle there is no boundary to wait for.
    assign apply_cfg  = pend_q & (period_end | ~en);

    assign os_cnt_nxt = (os_cnt_q == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt_q + 1'b1;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        div_int_d   = div_int_q;
        div_frac_d  = div_frac_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_int_d  = pend_int_q;
        pend_frac_d = pend_frac_q;
        os_tick_d   = 1'b0;
        os_cnt_d    = os_cnt_q;
        bit_tick_d  = 1'b0;
        mid_tick_d  = 1'b0;
        bclk_d      = bclk_q;
        cfg_err_d   = 1'b0;

        if (!en) begin
            cnt_d    = '0;
            acc_d    = '0;
            os_cnt_d = '0;
            bclk_d   = 1'b0;
        end else if (period_end) begin
            cnt_d      = '0;
            acc_d      = frac_sum[FRAC_W-1:0];
            os_tick_d  = 1'b1;
            os_cnt_d   = os_cnt_nxt;
            bit_tick_d = (os_cnt_nxt == '0);
            mid_tick_d = (os_cnt_nxt == OS_W'(OVERSAMPLE / 2));
            bclk_d     = ~bclk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // A new divisor starts from a clean fractional phase; os_cnt keeps
        // running so the bit framing is not disturbed.
        if (apply_cfg) begin
            div_int_d  = pend_int_q;
            div_frac_d = pend_frac_q;
            acc_d      = '0;
            pend_d     = 1'b0;
        end

        // cfg_xfer needs pend_q low, so it never collides with apply_cfg; an
        // offer taken on a boundary waits for the following boundary.
        if (cfg_xfer) begin
            if (cfg_bad) begin
                cfg_err_d = 1'b1;
            end else begin
                pend_d      = 1'b1;
                pend_int_d  = cfg.cfg_int;
                pend_frac_d = cfg.cfg_frac;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_int_q   <= INT_W'(RESET_DIV_INT);
            div_frac_q  <= FRAC_W'(RESET_DIV_FRAC);
            acc_q       <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            // NOTE: the pending payload is reset as well, so nothing undefined
            // can ever be copied into the active divisor.
            pend_int_q  <= '0;
            pend_frac_q <= '0;
            os_tick_q   <= 1'b0;
            os_cnt_q    <= '0;
            bit_tick_q  <= 1'b0;
            mid_tick_q  <= 1'b0;
            bclk_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            div_int_q   <= div_int_d;
            div_frac_q  <= div_frac_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
            os_tick_q   <= os_tick_d;
            os_cnt_q    <= os_cnt_d;
            bit_tick_q  <= bit_tick_d;
            mid_tick_q  <= mid_tick_d;
            bclk_q      <= bclk_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign os_tick       = os_tick_q;
    assign os_cnt        = os_cnt_q;
    assign bit_tick      = bit_tick_q;
    assign mid_tick      = mid_tick_q;
    assign bclk          = bclk_q;
    assign cfg.cfg_err   = cfg_err_q;
    assign cfg.cfg_ready = ~pend_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// -----------------------------------------------------------------------------
// tb_uart_baud_gen_frac
//   Scoreboard bench. The stimulus process drives one clock of inputs at a time
//   and asks the reference model what the DUT must show after that edge; the
//   prediction goes into a queue. A monitor pops one entry per falling edge and
//   compares it with the DUT outputs.
//   The model places oversample ticks with plain arithmetic: with divisor D in
//   1/16 clk units, tick k after a (re)start lands on clock floor(k*D/16).
// -----------------------------------------------------------------------------
module tb_uart_baud_gen_frac;
    localparam int INT_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OS     = 16;
    localparam int OS_W   = 4;
    localparam longint RESET_D = 3 * 16 + 12;

    logic            clk   = 1'b0;
    logic            reset = 1'b0;
    logic            en    = 1'b0;
    logic            os_tick;
    logic [OS_W-1:0] os_cnt;
    logic            bit_tick;
    logic            mid_tick;
    logic            bclk;

    uart_baud_gen_frac_if #(.INT_W(INT_W), .FRAC_W(FRAC_W)) cfg_if ();

    uart_baud_gen_frac #(
        .INT_W(INT_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OS),
        .RESET_DIV_INT(3), .RESET_DIV_FRAC(12)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .cfg      (cfg_if),
        .os_tick  (os_tick),
        .os_cnt   (os_cnt),
        .bit_tick (bit_tick),
        .mid_tick (mid_tick),
        .bclk     (bclk)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            os_tick;
        logic [OS_W-1:0] os_cnt;
        logic            bit_tick;
        logic            mid_tick;
        logic            bclk;
        logic            cfg_err;
        logic            cfg_ready;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state.
    longint m_t;     // enabled clocks since the last (re)start
    longint m_k;     // index of the next expected tick
    longint m_d;     // active divisor, 1/16 clk units
    longint m_pd;    // pending divisor
    bit     m_pend;
    int     m_os;
    bit     m_bclk;

    function automatic void model_reset();
        m_t    = 0;
        m_k    = 1;
        m_d    = RESET_D;
        m_pd   = 0;
        m_pend = 1'b0;
        m_os   = 0;
        m_bclk = 1'b0;
    endfunction

    // Predict the outputs after one clock edge with the given inputs.
    function automatic void model_step(bit r, bit e, bit v, int ci, int cf);
        obs_t o;
        bit   tick;
        bit   was_pend;
        o = '0;
        if (!r) begin
            model_reset();
            o.cfg_ready = 1'b1;
            exp_q.push_back(o);
            return;
        end
        was_pend = m_pend;
        tick     = 1'b0;
        if (e) begin
            m_t++;
            if (m_t == (m_k * m_d) / 16) begin
                tick = 1'b1;
                m_k++;
                m_os   = (m_os + 1) % OS;
                m_bclk = ~m_bclk;
            end
        end else begin
            m_t    = 0;
            m_k    = 1;
            m_os   = 0;
            m_bclk = 1'b0;
        end
        if (m_pend && (tick || !e)) begin
            m_d    = m_pd;
            m_pend = 1'b0;
            m_t    = 0;
            m_k    = 1;
        end
        if (v && !was_pend) begin
            if (ci < 2) o.cfg_err = 1'b1;
            else begin
                m_pend = 1'b1;
                m_pd   = longint'(ci) * 16 + longint'(cf);
            end
        end
        o.os_tick   = tick;
        o.os_cnt    = OS_W'(m_os);
        o.bit_tick  = tick && (m_os == 0);
        o.mid_tick  = tick && (m_os == OS / 2);
        o.bclk      = m_bclk;
        o.cfg_ready = !m_pend;
        exp_q.push_back(o);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive the inputs for the next rising edge and record the prediction.
    task automatic drive_cycle(input bit r, input bit e, input bit v, input int ci, input int cf);
        @(negedge clk);
        #1;
        reset            = r;
        en               = e;
        cfg_if.cfg_valid = v;
        cfg_if.cfg_int   = INT_W'(ci);
        cfg_if.cfg_frac  = FRAC_W'(cf);
        model_step(r, e, v, ci, cf);
    endtask

    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, e, 1'b0, 0, 0);
    endtask

    // Hold an offer until the model says it has been taken.
    task automatic offer(input int ci, input int cf);
        for (int i = 0; i < 64; i++) begin
            bit taken;
            taken = !m_pend;
            drive_cycle(1'b1, 1'b1, 1'b1, ci, cf);
            if (taken) break;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_os_tick"},   32'(os_tick),          32'd0);
        check({tag, "_os_cnt"},    32'(os_cnt),           32'd0);
        check({tag, "_bit_tick"},  32'(bit_tick),         32'd0);
        check({tag, "_mid_tick"},  32'(mid_tick),         32'd0);
        check({tag, "_bclk"},      32'(bclk),             32'd0);
        check({tag, "_cfg_err"},   32'(cfg_if.cfg_err),   32'd0);
        check({tag, "_cfg_ready"}, 32'(cfg_if.cfg_ready), 32'd1);
    endtask

    // Monitor: one prediction per clock, compared away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                obs_t e;
                obs_t a;
                e = exp_q.pop_front();
                a = '{os_tick, os_cnt, bit_tick, mid_tick, bclk, cfg_if.cfg_err, cfg_if.cfg_ready};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL obs @%0t: got tick=%b cnt=%0d bit=%b mid=%b bclk=%b err=%b rdy=%b, expected tick=%b cnt=%0d bit=%b mid=%b bclk=%b err=%b rdy=%b",
                             $time, a.os_tick, a.os_cnt, a.bit_tick, a.mid_tick, a.bclk, a.cfg_err, a.cfg_ready,
                             e.os_tick, e.os_cnt, e.bit_tick, e.mid_tick, e.bclk, e.cfg_err, e.cfg_ready);
                end
            end
        end
    end

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_int   = '0;
        cfg_if.cfg_frac  = '0;
        model_reset();
        #3;
        check_idle_outputs("reset");

        // Default 3.75 divisor: periods 3,4,4,4; bit every 60 clk, mid 30 later.
        drive_cycle(1'b0, 1'b0, 1'b0, 0, 0);
        drive_cycle(1'b0, 1'b0, 1'b0, 0, 0);
        run(2, 1'b0);
        run(130, 1'b1);

        // Legal update mid-period: old period finishes, then every 2 clk.
        drive_cycle(1'b1, 1'b1, 1'b1, 2, 0);
        run(20, 1'b1);

        // Illegal integer parts are rejected with cfg_err.
        drive_cycle(1'b1, 1'b1, 1'b1, 1, 0);
        drive_cycle(1'b1, 1'b1, 1'b1, 0, 5);
        run(10, 1'b1);

        // Second offer while one is pending waits for the boundary.
        offer(5, 8);
        offer(3, 4);
        run(40, 1'b1);

        // en low for 3 clk, then restart from a fresh period.
        run(3, 1'b0);
        run(30, 1'b1);

        // Offer while idle applies on the next edge.
        drive_cycle(1'b1, 1'b0, 1'b1, 4, 0);
        run(2, 1'b0);
        run(25, 1'b1);

        // Asynchronous reset mid-bit with an update pending.
        offer(7, 0);
        drive_cycle(1'b0, 1'b1, 1'b0, 0, 0);
        #1;
        check_idle_outputs("async_reset");
        drive_cycle(1'b0, 1'b1, 1'b0, 0, 0);
        run(70, 1'b1);

        // Random traffic: enable drop-outs and legal/illegal offers.
        for (int i = 0; i < 800; i++) begin
            bit e;
            bit v;
            e = ($urandom_range(0, 19) != 0);
            v = ($urandom_range(0, 7) == 0);
            drive_cycle(1'b1, e, v, int'($urandom_range(0, 6)), int'($urandom_range(0, 15)));
        end
        run(1, 1'b1);

        @(negedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
